// File: rtl/sccb_seq_master.sv
// SCCB master with a table-driven init sequencer and single-register
// host read/write access for OV-series camera sensors.
module sccb_seq_master #(
  parameter int         DIV       = 64,
  parameter int         TBL_AW    = 8,
  parameter logic [7:0] DEV_ID    = 8'h60,
  parameter int         DLY_UNIT  = 25000,
  parameter bit         ACK_CHECK = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [17:0]       tbl_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [7:0]        host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic              host_done,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              init_done,
  output logic              err,
  output logic              sioc,
  output logic              siod_oe,
  input  logic              siod_i
);

  localparam int QW = $clog2(DIV);
  localparam int DW = 8 + $clog2(DLY_UNIT);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, DECODE, XFER, DELAY, DONE
  } state_t;

  typedef enum logic [1:0] {
    S_START, S_BIT, S_STOP, S_GAP
  } seg_t;

  state_t        state, state_nx, adv_st;
  seg_t          seg;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;
  logic [3:0]    bcnt;
  logic [1:0]    bi;
  logic          rd, ph2, nack, hmode;
  logic [7:0]    x_addr, x_val, rx;
  logic [DW-1:0] dcnt;

  logic       qend, qlast, receiving, samp, ack_bad;
  logic       frame_end, restart, fin, tbl_last;
  logic       clr_walk, inc_addr, ld_tbl, ld_host, ld_dly;
  logic [7:0] cur_byte;
  logic [1:0] last_bi;
  logic       tx_bit, sioc_c, oe_c;
  logic [1:0] op;
  logic       dly_nz;

  assign op        = tbl_data[17:16];
  assign dly_nz    = |tbl_data[7:0];
  assign qend      = qcnt == QW'(DIV - 1);
  assign qlast     = qend && q == 2'd3;
  assign receiving = ph2 && bi == 2'd1;
  assign last_bi   = rd ? 2'd1 : 2'd2;
  assign tx_bit    = cur_byte[3'd7 - bcnt[2:0]];
  assign samp      = state == XFER && seg == S_BIT
                     && q == 2'd1 && qend;
  assign ack_bad   = ACK_CHECK && samp && !receiving
                     && bcnt == 4'd8 && siod_i;
  assign frame_end = state == XFER && seg == S_GAP && qlast;
  assign restart   = rd && !ph2 && !nack;
  assign fin       = frame_end && !restart;
  assign tbl_last  = tbl_addr == '1;
  assign adv_st    = tbl_last ? DONE : FETCH;
  assign busy      = state != IDLE && state != DONE;

  always_comb begin
    cur_byte = x_val;
    unique case (bi)
      2'd0:    cur_byte = ph2 ? (DEV_ID | 8'h01) : DEV_ID;
      2'd1:    cur_byte = x_addr;
      default: cur_byte = x_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr_walk = 1'b0;
    ld_tbl   = 1'b0;
    ld_host  = 1'b0;
    ld_dly   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = FETCH;
          clr_walk = 1'b1;
        end
      end
      FETCH: state_nx = WAIT;
      WAIT:  state_nx = DECODE;
      DECODE: begin
        unique case (1'b1)
          op == 2'b00: begin
            state_nx = XFER;
            ld_tbl   = 1'b1;
          end
          op == 2'b01 && dly_nz: begin
            state_nx = DELAY;
            ld_dly   = 1'b1;
          end
          op == 2'b01 && !dly_nz: state_nx = adv_st;
          default:                state_nx = DONE;
        endcase
      end
      XFER: begin
        if (fin) state_nx = (hmode || nack) ? DONE : adv_st;
      end
      DELAY: begin
        if (dcnt == DW'(1)) state_nx = adv_st;
      end
      DONE: begin
        if (start) begin
          state_nx = FETCH;
          clr_walk = 1'b1;
        end else if (host_req) begin
          state_nx = XFER;
          ld_host  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    inc_addr = state_nx == FETCH
               && state inside {DECODE, XFER, DELAY};
  end

  // Bus levels per segment and quarter; registered before the pins
  always_comb begin
    sioc_c = 1'b1;
    oe_c   = 1'b0;
    if (state == XFER) begin
      unique case (seg)
        S_START: oe_c = q[1];
        S_BIT: begin
          sioc_c = q[0] ^ q[1];
          oe_c   = bcnt != 4'd8 && !receiving && !tx_bit;
        end
        S_STOP: begin
          sioc_c = q != 2'd0;
          oe_c   = q != 2'd3;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_addr   <= '0;
      host_ack   <= 1'b0;
      host_done  <= 1'b0;
      host_rdata <= 8'h00;
      init_done  <= 1'b0;
      err        <= 1'b0;
      sioc       <= 1'b1;
      siod_oe    <= 1'b0;
      seg        <= S_START;
      qcnt       <= '0;
      q          <= 2'd0;
      bcnt       <= 4'd0;
      bi         <= 2'd0;
      rd         <= 1'b0;
      ph2        <= 1'b0;
      nack       <= 1'b0;
      hmode      <= 1'b0;
      x_addr     <= 8'h00;
      x_val      <= 8'h00;
      rx         <= 8'h00;
      dcnt       <= '0;
    end else begin
      host_ack  <= ld_host;
      host_done <= fin && hmode;
      sioc      <= sioc_c;
      siod_oe   <= oe_c;
      if (clr_walk)      tbl_addr <= '0;
      else if (inc_addr) tbl_addr <= tbl_addr + 1'b1;
      if (state_nx == DONE) init_done <= 1'b1;
      else if (clr_walk)    init_done <= 1'b0;
      if (clr_walk)     err <= 1'b0;
      else if (ack_bad) err <= 1'b1;
      if (ld_dly)
        dcnt <= DW'(tbl_data[7:0]) * DW'(DLY_UNIT);
      else if (state == DELAY)
        dcnt <= dcnt - 1'b1;
      if (fin && hmode && rd && !nack) host_rdata <= rx;
      if (ld_tbl || ld_host) begin
        seg    <= S_START;
        qcnt   <= '0;
        q      <= 2'd0;
        bcnt   <= 4'd0;
        bi     <= 2'd0;
        nack   <= 1'b0;
        ph2    <= 1'b0;
        hmode  <= ld_host;
        rd     <= ld_host && !host_we;
        x_addr <= ld_host ? host_addr : tbl_data[15:8];
        x_val  <= ld_host ? host_wdata : tbl_data[7:0];
      end else if (state == XFER) begin
        qcnt <= qend ? '0 : qcnt + 1'b1;
        if (qend) q <= q + 1'b1;
        if (samp && receiving && bcnt != 4'd8)
          rx <= {rx[6:0], siod_i};
        if (ack_bad) nack <= 1'b1;
        if (qlast) begin
          unique case (seg)
            S_START: seg <= S_BIT;
            S_BIT: begin
              if (bcnt == 4'd8) begin
                if (nack || bi == last_bi) begin
                  seg <= S_STOP;
                end else begin
                  bi   <= bi + 1'b1;
                  bcnt <= 4'd0;
                end
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
            S_STOP: seg <= S_GAP;
            default: begin
              // read: address phase done, restart for data
              if (restart) begin
                seg  <= S_START;
                ph2  <= 1'b1;
                bi   <= 2'd0;
                bcnt <= 4'd0;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
